// File: rtl/lfsr_share_pkg.sv
// Shared types and helpers for the shared-LFSR word sequencer.
package lfsr_share_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_GRANT = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 8;

  // Maximal-length feedback taps, right-aligned in an 8-bit container.
  function automatic logic [7:0] tap_mask(input int width);
    case (width)
      4:       return 8'h0C;
      5:       return 8'h14;
      6:       return 8'h30;
      7:       return 8'h60;
      8:       return 8'hB8;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit width_legal(input int width);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: seed load (zero seed forced to 1) or single step.
module lfsr_core
  import lfsr_share_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("lfsr_core: WIDTH must be within 4..8");
  end

  localparam logic [7:0]       TAP_ALL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS    = TAP_ALL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next state: load wins over step; an all-zero seed would lock up, so use 1.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (load_val == '0) ? ONE : load_val;
    end else if (step) begin
      q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/lfsr_share_ctrl.sv
// Round-robin sharing of one LFSR among NREQ requesters, one WORD-bit word per grant.
//
// state | meaning
// INIT  | load seed into the LFSR (after reset or a reseed)
// IDLE  | apply pending reseed, else pick next requester round robin
// GRANT | grant held, bit counter loaded
// SHIFT | step LFSR and collect one bit per cycle, WORD cycles
// DONE  | word_valid pulse, remember served requester
module lfsr_share_ctrl
  import lfsr_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int WORD  = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         seed,
  input  logic                     reseed,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          gnt,
  output logic [WORD-1:0]          word_out,
  output logic                     word_valid,
  output logic [$clog2(NREQ)-1:0]  word_id,
  output logic                     busy
);

  localparam int                ID_W     = $clog2(NREQ);
  localparam int                CNT_W    = $clog2(WORD);
  localparam logic [ID_W-1:0]   LAST_RST = ID_W'(NREQ - 1);
  localparam logic [NREQ-1:0]   GNT_ONE  = NREQ'(1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WORD - 1);

  state_e            state_q;
  logic              pending_q;
  logic [ID_W-1:0]   last_id_q;
  logic [ID_W-1:0]   win_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD-1:0]   shift_q;
  logic [WORD-1:0]   shift_d;
  logic [NREQ-1:0]   gnt_q;
  logic [WORD-1:0]   word_q;
  logic              valid_q;
  logic [ID_W-1:0]   id_q;
  logic              busy_q;

  logic              lfsr_load;
  logic              lfsr_step;
  logic [WIDTH-1:0]  lfsr_q;
  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   cand;

  assign lfsr_load = (state_q == ST_INIT);
  assign lfsr_step = (state_q == ST_SHIFT);
  assign shift_d   = {shift_q[WORD-2:0], lfsr_q[WIDTH-1]};

  lfsr_core #(.WIDTH(WIDTH)) u_core (
    .CLK      (CLK),
    .RST      (RST),
    .load     (lfsr_load),
    .load_val (seed),
    .step     (lfsr_step),
    .q        (lfsr_q)
  );

  // Round-robin search starting just after the last served requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ID_W'((int'(last_id_q) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_INIT;
      pending_q <= 1'b0;
      last_id_q <= LAST_RST;
      win_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      gnt_q     <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      busy_q    <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      if (reseed && (state_q != ST_IDLE)) pending_q <= 1'b1;
      case (state_q)
        ST_INIT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        ST_IDLE: begin
          if (reseed || pending_q) begin
            pending_q <= 1'b0;
            state_q   <= ST_INIT;
            busy_q    <= 1'b1;
          end else if (win_found) begin
            win_q   <= win_idx;
            gnt_q   <= GNT_ONE << win_idx;
            state_q <= ST_GRANT;
            busy_q  <= 1'b1;
          end
        end
        ST_GRANT: begin
          cnt_q   <= CNT_LOAD;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          shift_q <= shift_d;
          if (cnt_q == '0) begin
            word_q  <= shift_d;
            valid_q <= 1'b1;
            id_q    <= win_q;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          gnt_q     <= '0;
          last_id_q <= win_q;
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q <= ST_INIT;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign word_id    = id_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Bench for lfsr_share_ctrl: random requests checked against a bit-stream
// recurrence model of the LFSR and a plain round-robin model.
module tb_lfsr_share_ctrl;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int WORD  = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic [WIDTH-1:0] seed;
  logic             reseed;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [WORD-1:0]  word_out;
  logic             word_valid;
  logic [1:0]       word_id;
  logic             busy;

  always #5 CLK = ~CLK;

  lfsr_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .WORD(WORD)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .seed       (seed),
    .reseed     (reseed),
    .req        (req),
    .gnt        (gnt),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_id    (word_id),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output bit stream: with taps at q[3],q[2] and MSB-first output,
  // s[n+4] = s[n] ^ s[n+1]; the LFSR state is the next four stream bits.
  bit  stream[$];
  int  m_last;
  time t_valid;

  task automatic model_seed(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] v0;
    v0 = (v == '0) ? 4'd1 : v;
    stream.delete();
    for (int i = WIDTH - 1; i >= 0; i--) stream.push_back(v0[i]);
  endtask

  task automatic model_extend(input int n);
    while (stream.size() < n)
      stream.push_back(stream[stream.size()-4] ^ stream[stream.size()-3]);
  endtask

  task automatic model_take(output logic [WORD-1:0] w);
    model_extend(WORD + WIDTH);
    w = '0;
    for (int i = 0; i < WORD; i++) w = {w[WORD-2:0], stream.pop_front()};
  endtask

  function automatic logic [WIDTH-1:0] model_state();
    return {stream[0], stream[1], stream[2], stream[3]};
  endfunction

  bit onehot_bad = 0;
  bit watch_zero = 0;
  bit zero_seen  = 0;
  always @(posedge CLK) begin
    #1;
    if (!$onehot0(gnt)) onehot_bad = 1;
    if (watch_zero && dut.u_core.q == '0) zero_seen = 1;
  end

  // Entered at #1 after an edge with the DUT in IDLE; returns in the IDLE cycle after DONE.
  task automatic run_word(input logic [NREQ-1:0] reqv, input bit hold, input int rs_at);
    int win;
    int cyc;
    logic [WORD-1:0] w;
    win = -1;
    for (int k = 1; k <= NREQ; k++)
      if (win < 0 && reqv[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
    req = reqv;
    @(posedge CLK); #1;
    check("gnt_at_grant", gnt, 32'(1) << win);
    check("busy_grant", busy, 1);
    if (!hold) req = '0;
    cyc = 0;
    while (!word_valid && cyc < 40) begin
      reseed = (cyc == rs_at);
      @(posedge CLK); #1;
      cyc++;
    end
    reseed = 1'b0;
    check("valid_latency", cyc, WORD + 1);
    model_take(w);
    m_last = win;
    t_valid = $time;
    check("word_out", word_out, w);
    check("word_id", word_id, win);
    check("gnt_held_done", gnt, 32'(1) << win);
    check("q_after_word", dut.u_core.q, model_state());
    @(posedge CLK); #1;
    check("valid_pulse_end", word_valid, 0);
    check("word_hold", word_out, w);
    check("gnt_released", gnt, 0);
    check("idle_after_done", busy, 0);
  endtask

  task automatic do_reset(input logic [WIDTH-1:0] s);
    RST = 1'b1; seed = s; req = '0; reseed = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(posedge CLK); #1;
    check("idle_after_reset", busy, 0);
    model_seed(s);
    m_last = NREQ - 1;
    check("q_after_init", dut.u_core.q, model_state());
  endtask

  task automatic reseed_in_idle(input logic [WIDTH-1:0] s);
    seed = s;
    reseed = 1'b1;
    @(posedge CLK); #1;
    reseed = 1'b0;
    check("init_busy", busy, 1);
    @(posedge CLK); #1;
    check("idle_after_reseed", busy, 0);
    model_seed(s);
    check("q_after_reseed", dut.u_core.q, model_state());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_prev;
    int  vseen;
    logic [WIDTH-1:0] s;

    RST = 1'b1; seed = 4'b1001; reseed = 1'b0; req = '0;
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_word_out", word_out, 0);
    check("rst_word_valid", word_valid, 0);
    check("rst_word_id", word_id, 0);
    check("rst_busy", busy, 1);
    check("rst_q", dut.u_core.q, 0);
    do_reset(4'b1001);

    // basic word and stream continuity
    run_word(4'b0001, 0, -1);
    run_word(4'b0010, 0, -1);

    // round robin with all requests held
    do_reset(4'b1001);
    run_word(4'b1111, 1, -1);
    t_prev = t_valid;
    for (int i = 0; i < 4; i++) begin
      run_word(4'b1111, 1, -1);
      check("rr_period", 32'(t_valid - t_prev), (WORD + 3) * 10);
      t_prev = t_valid;
    end
    req = '0;

    // random requests with occasional random reseeds
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        s = WIDTH'($urandom_range(0, 15));
        reseed_in_idle(s);
      end
      run_word(NREQ'($urandom_range(1, 15)), 0, -1);
    end

    // reseed pulsed mid-SHIFT: word completes, INIT after the following IDLE
    seed = 4'b1001;
    run_word(NREQ'($urandom_range(1, 15)), 0, 3);
    @(posedge CLK); #1;
    check("pending_init_busy", busy, 1);
    check("pending_init_gnt", gnt, 0);
    @(posedge CLK); #1;
    check("pending_idle", busy, 0);
    model_seed(4'b1001);
    run_word(NREQ'($urandom_range(1, 15)), 0, -1);

    // zero seed
    reseed_in_idle(4'b0000);
    watch_zero = 1;
    for (int i = 0; i < 4; i++) run_word(NREQ'($urandom_range(1, 15)), 0, -1);
    watch_zero = 0;
    check("no_zero_state", zero_seen, 0);

    // async reset in the middle of a word
    req = 4'b0100;
    @(posedge CLK); #1;
    req = '0;
    repeat (3) @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    check("arst_gnt", gnt, 0);
    check("arst_busy", busy, 1);
    check("arst_word_valid", word_valid, 0);
    check("arst_word_out", word_out, 0);
    check("arst_word_id", word_id, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    vseen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (word_valid) vseen++;
    end
    check("arst_no_valid", vseen, 0);
    check("arst_idle", busy, 0);

    check("gnt_onehot", onehot_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
